counter_updown_mod: RTL and testbench
=====================================

// Module: counter_updown_mod
// PURPOSE
//  Parametrised up/down modulo counter; successor to the fixed 2-bit free-running counter.
//  Adds width/modulus parameters, enable, direction, sync clear, parallel load, terminal-count and wrap flags.
//  Used as the timebase/index generator for week-level designs (clock dividers, FSM timers, address walk).
// PARAMETERS
//  WIDTH    8               counter width in bits (>=1)
//  MAX_VAL  (1<<WIDTH)-1    highest count value; counter runs 0..MAX_VAL (modulus MAX_VAL+1); must be < 2**WIDTH
//  RST_VAL  0               value loaded by rst_n and clr_i; must be <= MAX_VAL
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  en_i        in   1      count enable (one step per clk while high)
//  up_i        in   1      direction: 1 = increment, 0 = decrement
//  clr_i       in   1      synchronous clear to RST_VAL
//  load_i      in   1      synchronous parallel load
//  load_val_i  in   WIDTH  load value
//  sat_i       in   1      saturate mode select (present only with COUNTER_SAT_EN)
//  count_o     out  WIDTH  registered count
//  tc_o        out  1      terminal count, combinational: en_i & ((up_i & count==MAX_VAL) | (~up_i & count==0))
//  wrap_o      out  1      registered 1-cycle pulse, cycle after a wrap occurred
// BEHAVIOUR
//  - Reset (rst_n=0, async, any time incl. mid-count): count_o=RST_VAL, wrap_o=0 immediately; tc_o follows.
//  - Per-edge priority: clr_i > load_i > en_i > hold. Latency 1 clk from input to count_o.
//  - clr_i: count<=RST_VAL, wrap_o<=0, regardless of load_i/en_i.
//  - load_i: count<=load_val_i; if load_val_i>MAX_VAL, count<=MAX_VAL (clamp). wrap_o<=0.
//  - en_i & up_i: count<MAX_VAL -> count+1; count==MAX_VAL -> 0, wrap_o<=1.
//  - en_i & ~up_i: count>0 -> count-1; count==0 -> MAX_VAL, wrap_o<=1.
//  - en_i=0, no clr/load: count holds, wrap_o<=0.
//  - Direction change is legal any cycle; takes effect on the same edge.
//  - Arithmetic on WIDTH bits; compare against MAX_VAL, never rely on natural 2**WIDTH rollover.
//  - WIDTH=1, MAX_VAL=1 must toggle correctly in both directions.
// CONFIGURATION
//  Macro COUNTER_SAT_EN:
//  - defined: sat_i port exists; with sat_i=1 the counter stops at MAX_VAL (up) / 0 (down),
//    wrap_o stays 0, tc_o still asserts at the boundary; sat_i=0 gives wrap behaviour.
//  - undefined: no sat_i port; always wraps as described above.
// STRUCTURE
//  - Package counter_pkg: localparams DIR_UP=1'b1, DIR_DOWN=1'b0; function clamp_load(value, max).
//  - Sub-module counter_next: pure combinational next-count + wrap-detect from
//    (count, en, up, sat, MAX_VAL); top holds only the registers and the clr/load priority mux.
// TESTING  (WIDTH=4, MAX_VAL=9, RST_VAL=0 unless noted)
//  1. rst_n=0 while counting at 5 -> count_o=0, wrap_o=0 same cycle, no clk needed.
//  2. en_i=1, up_i=1 for 12 clks from 0 -> 1..9,0,1,2; wrap_o=1 only the cycle after 9->0; tc_o=1 while count=9.
//  3. en_i=1, up_i=0 from 0 -> 9,8,7; wrap_o pulses once; tc_o=1 at count 0.
//  4. load_i=1 with load_val_i=6 and en_i=1 -> count_o=6; load_val_i=13 -> count_o=9; clr_i+load_i together -> 0.
//  5. en_i toggled 1/0 each clk, up_i flipped at count 3 -> 1,1,2,2,3,3,2,2: holds when disabled, direction applied same edge.
//  6. COUNTER_SAT_EN, sat_i=1, counting up from 8 -> 9,9,9, wrap_o=0, tc_o=1; WIDTH=1,MAX_VAL=1 build toggles 0,1,0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
// Optional feature macro used by this design: COUNTER_SAT_EN (saturate mode).
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Limit a parallel-load value to the highest legal count.
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Pure combinational next-count, wrap detect and terminal-count for the
// up/down modulo counter. Compares against MAX_VAL explicitly so a modulus
// that is not a power of two wraps correctly.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  logic at_max;
  logic at_zero;

  assign at_max  = (count == MAX_C);
  assign at_zero = (count == '0);

  // Step by one in the selected direction; wrap or stop at the boundary.
  always_comb begin
    next_count = count;
    wrap       = 1'b0;
    tc         = en & (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_zero));
    if (en) begin
      if (up == DIR_UP) begin
        if (!at_max) begin
          next_count = count + ONE_C;
        end else if (!sat) begin
          next_count = '0;
          wrap       = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          next_count = count - ONE_C;
        end else if (!sat) begin
          next_count = MAX_C;
          wrap       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with enable, sync clear, parallel load,
// terminal-count and wrap flags. Define COUNTER_SAT_EN to add the sat_i port
// (saturate at the boundary instead of wrapping).
// There is no handshake: all control inputs are sampled on every rising edge,
// with priority clr_i > load_i > en_i > hold. Supports WIDTH from 1 to 31.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
`ifdef COUNTER_SAT_EN
  input  logic             sat_i,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             sat;
  logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_SAT_EN
  assign sat = sat_i;
`else
  assign sat = 1'b0;
`endif

  assign load_clamped = WIDTH'(clamp_load(32'(load_val_i), 32'(MAX_VAL)));

  counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count      (count_q),
    .en         (en_i),
    .up         (up_i),
    .sat        (sat),
    .next_count (next_count),
    .wrap       (next_wrap),
    .tc         (tc_o)
  );

  // Count and wrap-pulse registers with clear/load priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
    end else if (clr_i) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
    end else if (load_i) begin
      count_q <= load_clamped;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= next_count;
      wrap_q  <= next_wrap;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: a WIDTH=4/MAX_VAL=9 instance plus a
// WIDTH=1/MAX_VAL=1 instance. Expected {wrap, count} values are queued by the
// driver and compared by a monitor one step after each rising edge.
module tb_counter_updown_mod;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       en, up, clr, load;
  logic [3:0] load_val;
  logic       sat_v;
  logic [3:0] count;
  logic       tc, wrap;

  logic       en1, up1;
  logic [0:0] count1;
  logic       tc1, wrap1;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  logic [1:0] exp1_q[$];

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .up_i       (up),
    .clr_i      (clr),
    .load_i     (load),
    .load_val_i (load_val),
`ifdef COUNTER_SAT_EN
    .sat_i      (sat_v),
`endif
    .count_o    (count),
    .tc_o       (tc),
    .wrap_o     (wrap)
  );

  counter_updown_mod #(.WIDTH(1), .MAX_VAL(1), .RST_VAL(0)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en1),
    .up_i       (up1),
    .clr_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i (1'b0),
`ifdef COUNTER_SAT_EN
    .sat_i      (1'b0),
`endif
    .count_o    (count1),
    .tc_o       (tc1),
    .wrap_o     (wrap1)
  );

  // ---------------- scoreboard monitor ----------------
  logic [4:0] e_main;
  logic [1:0] e_one;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_main = exp_q.pop_front();
      checks++;
      if ({wrap, count} !== e_main) begin
        errors++;
        $display("FAIL main_out: got wrap=%b count=%0d, expected wrap=%b count=%0d",
                 wrap, count, e_main[4], e_main[3:0]);
      end
    end
    if (exp1_q.size() > 0) begin
      e_one = exp1_q.pop_front();
      checks++;
      if ({wrap1, count1} !== e_one) begin
        errors++;
        $display("FAIL w1_out: got wrap=%b count=%0d, expected wrap=%b count=%0d",
                 wrap1, count1, e_one[1], e_one[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic s_en, input logic s_up, input logic s_clr,
                      input logic s_load, input logic [3:0] s_lv,
                      input logic [3:0] x_cnt, input logic x_wrap, input logic x_tc,
                      input string name);
    @(negedge clk);
    en = s_en; up = s_up; clr = s_clr; load = s_load; load_val = s_lv;
    exp_q.push_back({x_wrap, x_cnt});
    #1;
    checks++;
    if (tc !== x_tc) begin
      errors++;
      $display("FAIL tc %s: got %b expected %b (count=%0d)", name, tc, x_tc, count);
    end
  endtask

  task automatic step1(input logic s_en, input logic s_up,
                       input logic x_cnt, input logic x_wrap, input logic x_tc);
    @(negedge clk);
    en1 = s_en; up1 = s_up;
    exp1_q.push_back({x_wrap, x_cnt});
    #1;
    checks++;
    if (tc1 !== x_tc) begin
      errors++;
      $display("FAIL w1_tc: got %b expected %b (count=%0d)", tc1, x_tc, count1);
    end
  endtask

  task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  logic [3:0] up_tbl [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                              4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

  initial begin
    en = 0; up = 1; clr = 0; load = 0; load_val = '0; sat_v = 0;
    en1 = 0; up1 = 1;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_now("reset_count", {4'd0, count}, 8'd0);
    check_now("reset_wrap", {7'd0, wrap}, 8'd0);
    check_now("reset_count_w1", {7'd0, count1}, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up 12 steps from 0: 1..9,0,1,2; wrap after 9->0, tc while at 9.
    for (int i = 0; i < 12; i++)
      step(1, 1, 0, 0, 4'd0, up_tbl[i], (i == 9), (i == 9), "up_run");

    // Clear beats load and enable.
    step(1, 1, 1, 1, 4'd5, 4'd0, 0, 0, "clr_prio");

    // Count down from 0: 9,8,7 with a single wrap pulse.
    step(1, 0, 0, 0, 4'd0, 4'd9, 1, 1, "down_wrap");
    step(1, 0, 0, 0, 4'd0, 4'd8, 0, 0, "down_8");
    step(1, 0, 0, 0, 4'd0, 4'd7, 0, 0, "down_7");

    // Load over enable, clamp, load at terminal count, clear with load.
    step(1, 1, 0, 1, 4'd6,  4'd6, 0, 0, "load_6");
    step(0, 1, 0, 1, 4'd13, 4'd9, 0, 0, "load_clamp");
    step(1, 1, 0, 1, 4'd3,  4'd3, 0, 1, "load_at_tc");
    step(0, 1, 1, 1, 4'd7,  4'd0, 0, 0, "clr_load");

    // Enable toggling with a direction flip at count 3.
    step(1, 1, 0, 0, 4'd0, 4'd1, 0, 0, "tog_1");
    step(0, 1, 0, 0, 4'd0, 4'd1, 0, 0, "tog_hold1");
    step(1, 1, 0, 0, 4'd0, 4'd2, 0, 0, "tog_2");
    step(0, 1, 0, 0, 4'd0, 4'd2, 0, 0, "tog_hold2");
    step(1, 1, 0, 0, 4'd0, 4'd3, 0, 0, "tog_3");
    step(0, 0, 0, 0, 4'd0, 4'd3, 0, 0, "tog_hold3");
    step(1, 0, 0, 0, 4'd0, 4'd2, 0, 0, "tog_dn2");
    step(0, 0, 0, 0, 4'd0, 4'd2, 0, 0, "tog_hold4");

`ifdef COUNTER_SAT_EN
    // Saturate at 9 going up and at 0 going down; no wrap pulse.
    step(0, 1, 0, 1, 4'd8, 4'd8, 0, 0, "sat_load8");
    sat_v = 1;
    step(1, 1, 0, 0, 4'd0, 4'd9, 0, 0, "sat_up9");
    step(1, 1, 0, 0, 4'd0, 4'd9, 0, 1, "sat_hold9a");
    step(1, 1, 0, 0, 4'd0, 4'd9, 0, 1, "sat_hold9b");
    step(0, 1, 0, 1, 4'd1, 4'd1, 0, 0, "sat_load1");
    step(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, "sat_dn0");
    step(1, 0, 0, 0, 4'd0, 4'd0, 0, 1, "sat_hold0");
    sat_v = 0;
    step(0, 1, 0, 1, 4'd2, 4'd2, 0, 0, "sat_reload2");
`endif

    // Count up to 5, then reset asynchronously mid-cycle.
    step(1, 1, 0, 0, 4'd0, 4'd3, 0, 0, "pre_rst3");
    step(1, 1, 0, 0, 4'd0, 4'd4, 0, 0, "pre_rst4");
    step(1, 1, 0, 0, 4'd0, 4'd5, 0, 0, "pre_rst5");
    @(negedge clk);
    en = 1; up = 0;
    #2 rst_n = 1'b0;
    #1;
    check_now("midrun_rst_count", {4'd0, count}, 8'd0);
    check_now("midrun_rst_wrap", {7'd0, wrap}, 8'd0);
    check_now("midrun_rst_tc", {7'd0, tc}, 8'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    en = 0;
    rst_n = 1'b1;

    // WIDTH=1, MAX_VAL=1 toggles in both directions.
    step1(1, 1, 1'b1, 0, 0);
    step1(1, 1, 1'b0, 1, 1);
    step1(1, 1, 1'b1, 0, 0);
    step1(1, 0, 1'b0, 0, 0);
    step1(1, 0, 1'b1, 1, 1);
    step1(1, 0, 1'b0, 0, 0);
    step1(0, 0, 1'b0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0",
               exp_q.size(), exp1_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
